ime_bist_seq: RTL and testbench
===============================

IME_BIST_SEQ -- requirements
Module: ime_bist_seq

Interface
REQ-001 SHALL have parameter W_P, default 16, probability field width.
REQ-002 SHALL have parameter W_LOG, default 16, score field width.
REQ-003 SHALL have parameter W_ACC, default 32, accumulator width.
REQ-004 SHALL have parameter DEPTH, default 64, maximum beats per frame (power of two, at most 65535).
REQ-005 SHALL have parameter TO_CYCLES, default 1024, maximum WAIT cycles per frame before timeout.
REQ-006 SHALL have the following ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset; asynchronous, active-low.
- bist_cmd  in  2  01 = start, 10 = abort, other values = no-op.
- vect_sel  in  3  0 = Uniform, 1 = Dirac, 2 = SymPerturb, 3 = LFSR, 4-7 = illegal.
- tol  in  8  absolute tolerance on the accumulator result.
- frame_len  in  16  beats per frame.
- loop_cnt  in  8  number of frames per run.
- lfsr_seed  in  16  LFSR seed.
- exp_acc  in  W_ACC  expected result for LFSR mode.
- stop_on_fail  in  1  end the run on the first failed frame.
- bist_active  out  1  high in STREAM or WAIT.
- bist_tdata  out  2*W_P+W_LOG  stimulus beat, {prob_p, prob_q, score}.
- bist_tuser  out  8  {vect_sel, index[4:0]}.
- bist_tvalid  out  1  stimulus valid.
- bist_tready  in  1  stimulus ready.
- bist_tlast  out  1  last beat of frame.
- obs_acc  in  W_ACC  observed accumulator value.
- obs_tuser  in  8  observed tag.
- obs_valid  in  1  observation valid.
- obs_last  in  1  observation is frame end.
- bist_status  out  2  00 = IDLE, 01 = RUN, 10 = PASS, 11 = FAIL.
- poison_inject  out  1  high while status is FAIL.
- fail_count  out  8  failed frames in the current run.
- frames_done  out  8  completed frames in the current run.
- timeout_flag  out  1  at least one frame in the run timed out.

Function
REQ-007 SHALL implement states IDLE, STREAM, WAIT and DONE.
REQ-008 SHALL give abort priority over all other events; abort SHALL go to IDLE with status IDLE and clear all counters and flags.
REQ-009 On start, in any state, SHALL latch the configuration, clear counters and flags, set status RUN, set index to 0, load the LFSR, and enter STREAM.
REQ-010 SHALL latch frame length as DEPTH when frame_len is 0 or greater than DEPTH, otherwise frame_len; SHALL latch loop count as 1 when loop_cnt is 0, otherwise loop_cnt.
REQ-011 SHALL reject a start with vect_sel 4-7 by entering DONE with status FAIL, poison_inject 1 and fail_count 1.
REQ-012 SHALL assert bist_tvalid only in STREAM, and SHALL hold bist_tdata, bist_tuser and bist_tlast stable while bist_tvalid is 1 and bist_tready is 0.
REQ-013 SHALL advance index on each accepted beat (tvalid and tready both 1); bist_tlast SHALL be 1 when index equals frame length minus 1; acceptance of the last beat SHALL enter WAIT.
REQ-014 SHALL generate fixed-mode vectors from a 4-entry table indexed by index[1:0]:
- Uniform: (1024,1024,2048), (1024,2048,1536), (2048,1024,1280), (2048,2048,1024).
- Dirac: (4096,128,4096), (64,128,256), then (32,256,128) for entries 2 and 3.
- SymPerturb: (1536,1664,1408), (1664,1536,1344), then (1600,1600,1312) for entries 2 and 3.
REQ-015 In LFSR mode SHALL use a 16-bit Galois LFSR with mask 0xB400, reloaded from lfsr_seed at the start of every frame (seed 0 replaced by 0x0001) and stepped on each accepted beat; the beat SHALL be prob_p = state, prob_q = bitwise NOT of state, score = state rotated by 8, each zero-extended or truncated to its field width.
REQ-016 SHALL use expected values Uniform 4096, Dirac 8192, SymPerturb 2048, LFSR exp_acc.
REQ-017 In WAIT, obs_valid and obs_last both 1 SHALL mark the frame as passing only if |obs_acc - expected| <= tol (zero-extended), obs_tuser[7:5] equals the latched vect_sel, and obs_tuser[4:0] equals (frame length - 1)[4:0].
REQ-018 SHALL count WAIT cycles from 0; reaching TO_CYCLES-1 without a qualifying observation SHALL fail the frame and set timeout_flag; an observation arriving in that same cycle SHALL take precedence over the timeout.
REQ-019 SHALL ignore observations outside WAIT.
REQ-020 On frame end SHALL increment frames_done and, on failure, fail_count (saturating at 255); SHALL enter DONE if frames_done reaches the loop count or if the frame failed with stop_on_fail at 1; otherwise SHALL re-enter STREAM with index 0.
REQ-021 On entry to DONE SHALL set status PASS if fail_count is 0, otherwise FAIL with poison_inject 1; DONE SHALL hold until start or abort.

Reset
REQ-022 While rst_n is low SHALL force state IDLE, status 00, all outputs 0, index 0, latched frame length 1, latched loop count 1 and LFSR state 0x0001; assertion mid-run SHALL abandon the run with no further beats.

Structure
REQ-023 SHALL take from package ime_bist_pkg: the state enum, status codes, command codes, vector struct, table constants and expected constants.
REQ-024 SHALL implement the LFSR in sub-module ime_bist_lfsr, with ports load, seed, step and state.

Verification
REQ-025 Uniform, frame_len 4, loop_cnt 3, tol 8, each frame answered with obs_acc 4100 and tuser 0x03 -> PASS, frames_done 3, fail_count 0.
REQ-026 Dirac, frame_len 0, bist_tready toggling -> 64 beats per frame, tlast on index 63, data stable during stalls.
REQ-027 SymPerturb, loop_cnt 2, no observation, TO_CYCLES 16 -> two timeouts, FAIL, fail_count 2, timeout_flag 1, poison_inject 1.
REQ-028 LFSR, seed 0, exp_acc 500, obs_acc 520, tol 8, stop_on_fail 1, loop_cnt 4 -> FAIL after frames_done 1; both frames of a rerun with loop_cnt 2 start with beat state 0x0001.
REQ-029 Abort during STREAM at index 2 -> IDLE, bist_tvalid 0 on the next cycle, counters 0; vect_sel 5 start -> immediate FAIL.

Source files
------------

// File: rtl/ime_bist_pkg.sv
// Shared types and constants for the inference-engine BIST sequencer:
// FSM states, status/command codes, the stimulus vector layout and its tables.
package ime_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STAT_IDLE = 2'b00,
    STAT_RUN  = 2'b01,
    STAT_PASS = 2'b10,
    STAT_FAIL = 2'b11
  } status_e;

  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_ABORT = 2'b10;

  localparam logic [2:0] SEL_UNIFORM = 3'd0;
  localparam logic [2:0] SEL_DIRAC   = 3'd1;
  localparam logic [2:0] SEL_SYMPERT = 3'd2;
  localparam logic [2:0] SEL_LFSR    = 3'd3;

  typedef struct packed {
    logic [15:0] prob_p;
    logic [15:0] prob_q;
    logic [15:0] score;
  } vec_t;

  localparam vec_t UNIFORM_TBL [4] = '{
    '{16'd1024, 16'd1024, 16'd2048},
    '{16'd1024, 16'd2048, 16'd1536},
    '{16'd2048, 16'd1024, 16'd1280},
    '{16'd2048, 16'd2048, 16'd1024}
  };

  localparam vec_t DIRAC_TBL [4] = '{
    '{16'd4096, 16'd128, 16'd4096},
    '{16'd64,   16'd128, 16'd256},
    '{16'd32,   16'd256, 16'd128},
    '{16'd32,   16'd256, 16'd128}
  };

  localparam vec_t SYMPERT_TBL [4] = '{
    '{16'd1536, 16'd1664, 16'd1408},
    '{16'd1664, 16'd1536, 16'd1344},
    '{16'd1600, 16'd1600, 16'd1312},
    '{16'd1600, 16'd1600, 16'd1312}
  };

  localparam logic [31:0] EXP_UNIFORM = 32'd4096;
  localparam logic [31:0] EXP_DIRAC   = 32'd8192;
  localparam logic [31:0] EXP_SYMPERT = 32'd2048;

  localparam logic [15:0] LFSR_MASK  = 16'hB400;
  localparam logic [15:0] LFSR_RESET = 16'h0001;

  function automatic vec_t fixed_vec(input logic [2:0] sel, input logic [1:0] idx);
    case (sel)
      SEL_UNIFORM: return UNIFORM_TBL[idx];
      SEL_DIRAC:   return DIRAC_TBL[idx];
      SEL_SYMPERT: return SYMPERT_TBL[idx];
      default:     return '0;
    endcase
  endfunction

endpackage

// File: rtl/ime_bist_lfsr.sv
// 16-bit Galois LFSR (mask 0xB400) used as the pseudo-random stimulus source.
// Load wins over step; a zero seed would lock the register, so it becomes 0x0001.
module ime_bist_lfsr
  import ime_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // NOTE: default assignment first so no path through always_comb infers a latch.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == 16'd0) ? LFSR_RESET : seed;
    end else if (step) begin
      state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_MASK : 16'd0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/ime_bist_seq.sv
// BIST sequencer: streams directed or LFSR stimulus frames to the engine, checks the
// returned accumulator per frame against a tolerance, and reports run status.
module ime_bist_seq
  import ime_bist_pkg::*;
#(
  parameter int W_P       = 16,
  parameter int W_LOG     = 16,
  parameter int W_ACC     = 32,
  parameter int DEPTH     = 64,
  parameter int TO_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               bist_cmd,
  input  logic [2:0]               vect_sel,
  input  logic [7:0]               tol,
  input  logic [15:0]              frame_len,
  input  logic [7:0]               loop_cnt,
  input  logic [15:0]              lfsr_seed,
  input  logic [W_ACC-1:0]         exp_acc,
  input  logic                     stop_on_fail,
  output logic                     bist_active,
  output logic [2*W_P+W_LOG-1:0]   bist_tdata,
  output logic [7:0]               bist_tuser,
  output logic                     bist_tvalid,
  input  logic                     bist_tready,
  output logic                     bist_tlast,
  input  logic [W_ACC-1:0]         obs_acc,
  input  logic [7:0]               obs_tuser,
  input  logic                     obs_valid,
  input  logic                     obs_last,
  output logic [1:0]               bist_status,
  output logic                     poison_inject,
  output logic [7:0]               fail_count,
  output logic [7:0]               frames_done,
  output logic                     timeout_flag
);

  localparam int              WC_W    = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [WC_W-1:0] TO_LAST = WC_W'(TO_CYCLES - 1);
  localparam logic [15:0]     DEPTH_L = 16'(DEPTH);

  state_e             state_q;
  status_e            status_q;
  logic [15:0]        idx_q;
  logic [15:0]        len_q;
  logic [7:0]         loops_q;
  logic [7:0]         fail_q;
  logic [7:0]         frames_q;
  logic               to_flag_q;
  logic [WC_W-1:0]    wcnt_q;
  logic [2:0]         sel_q;
  logic [7:0]         tol_q;
  logic [15:0]        seed_q;
  logic [W_ACC-1:0]   exp_q;
  logic               sof_q;

  logic               cmd_start, cmd_abort;
  logic               in_stream, in_wait;
  logic [15:0]        last_idx;
  logic               last_beat, beat_acc;
  logic               obs_hit, obs_ok, timeout_hit, frame_end, frame_fail, run_over;
  logic [W_ACC-1:0]   acc_diff;
  logic [W_ACC-1:0]   exp_sel;
  logic [7:0]         frames_d;
  logic [7:0]         fail_d;
  logic               lfsr_load, lfsr_step;
  logic [15:0]        lfsr_seed_mux;
  logic [15:0]        lfsr_state;
  vec_t               vec;

  ime_bist_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (lfsr_seed_mux),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  always_comb begin
    cmd_start   = (bist_cmd == CMD_START);
    cmd_abort   = (bist_cmd == CMD_ABORT);
    in_stream   = (state_q == ST_STREAM);
    in_wait     = (state_q == ST_WAIT);
    last_idx    = len_q - 16'd1;
    last_beat   = (idx_q == last_idx);
    beat_acc    = in_stream && bist_tready;

    acc_diff    = (obs_acc >= exp_q) ? (obs_acc - exp_q) : (exp_q - obs_acc);
    obs_ok      = (acc_diff <= W_ACC'(tol_q)) &&
                  (obs_tuser[7:5] == sel_q) &&
                  (obs_tuser[4:0] == last_idx[4:0]);
    obs_hit     = in_wait && obs_valid && obs_last;
    // A qualifying observation in the final WAIT cycle beats the timeout.
    timeout_hit = in_wait && !obs_hit && (wcnt_q == TO_LAST);
    frame_end   = obs_hit || timeout_hit;
    frame_fail  = timeout_hit || (obs_hit && !obs_ok);

    frames_d    = frames_q + 8'd1;
    fail_d      = (frame_fail && fail_q != 8'hFF) ? fail_q + 8'd1 : fail_q;
    run_over    = (frames_d == loops_q) || (frame_fail && sof_q);

    case (vect_sel)
      SEL_UNIFORM: exp_sel = W_ACC'(EXP_UNIFORM);
      SEL_DIRAC:   exp_sel = W_ACC'(EXP_DIRAC);
      SEL_SYMPERT: exp_sel = W_ACC'(EXP_SYMPERT);
      default:     exp_sel = exp_acc;
    endcase

    lfsr_seed_mux = cmd_start ? lfsr_seed : seed_q;
    lfsr_load     = !cmd_abort && (cmd_start ? !vect_sel[2] : (frame_end && !run_over));
    lfsr_step     = !cmd_abort && !cmd_start && beat_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      status_q  <= STAT_IDLE;
      idx_q     <= 16'd0;
      len_q     <= 16'd1;
      loops_q   <= 8'd1;
      fail_q    <= 8'd0;
      frames_q  <= 8'd0;
      to_flag_q <= 1'b0;
      wcnt_q    <= '0;
      sel_q     <= 3'd0;
      tol_q     <= 8'd0;
      seed_q    <= 16'd0;
      exp_q     <= '0;
      sof_q     <= 1'b0;
    end else if (cmd_abort) begin
      state_q   <= ST_IDLE;
      status_q  <= STAT_IDLE;
      idx_q     <= 16'd0;
      fail_q    <= 8'd0;
      frames_q  <= 8'd0;
      to_flag_q <= 1'b0;
      wcnt_q    <= '0;
    end else if (cmd_start) begin
      sel_q     <= vect_sel;
      tol_q     <= tol;
      seed_q    <= lfsr_seed;
      exp_q     <= exp_sel;
      sof_q     <= stop_on_fail;
      len_q     <= (frame_len == 16'd0 || frame_len > DEPTH_L) ? DEPTH_L : frame_len;
      loops_q   <= (loop_cnt == 8'd0) ? 8'd1 : loop_cnt;
      idx_q     <= 16'd0;
      frames_q  <= 8'd0;
      to_flag_q <= 1'b0;
      wcnt_q    <= '0;
      if (vect_sel[2]) begin
        state_q  <= ST_DONE;
        status_q <= STAT_FAIL;
        fail_q   <= 8'd1;
      end else begin
        state_q  <= ST_STREAM;
        status_q <= STAT_RUN;
        fail_q   <= 8'd0;
      end
    end else begin
      case (state_q)
        ST_STREAM: begin
          if (beat_acc) begin
            idx_q <= idx_q + 16'd1;
            if (last_beat) begin
              state_q <= ST_WAIT;
              wcnt_q  <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (frame_end) begin
            frames_q <= frames_d;
            fail_q   <= fail_d;
            if (timeout_hit) to_flag_q <= 1'b1;
            if (run_over) begin
              state_q  <= ST_DONE;
              status_q <= (fail_d == 8'd0) ? STAT_PASS : STAT_FAIL;
            end else begin
              state_q <= ST_STREAM;
              idx_q   <= 16'd0;
            end
          end else begin
            wcnt_q <= wcnt_q + WC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Beat content: table entry for fixed modes, LFSR-derived fields otherwise.
  always_comb begin
    vec = fixed_vec(sel_q, idx_q[1:0]);
    if (sel_q == SEL_LFSR) begin
      vec.prob_p = lfsr_state;
      vec.prob_q = ~lfsr_state;
      vec.score  = {lfsr_state[7:0], lfsr_state[15:8]};
    end
  end

  assign bist_active   = in_stream || in_wait;
  assign bist_tvalid   = in_stream;
  assign bist_tlast    = in_stream && last_beat;
  assign bist_tuser    = in_stream ? {sel_q, idx_q[4:0]} : 8'd0;
  assign bist_tdata    = in_stream ? {W_P'(vec.prob_p), W_P'(vec.prob_q), W_LOG'(vec.score)} : '0;
  assign bist_status   = status_q;
  assign poison_inject = (status_q == STAT_FAIL);
  assign fail_count    = fail_q;
  assign frames_done   = frames_q;
  assign timeout_flag  = to_flag_q;

endmodule

// File: tb/tb_ime_bist_seq.sv
// Self-checking bench for ime_bist_seq: a frame-level beat model feeds a per-cycle
// compare process; directed runs check end-of-run status against hand values.
module tb_ime_bist_seq;
  localparam int W_P = 16, W_LOG = 16, W_ACC = 32, DEPTH = 64, TO_CYCLES = 16;
  localparam int TD_W = 2 * W_P + W_LOG;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        bist_cmd = '0;
  logic [2:0]        vect_sel = '0;
  logic [7:0]        tol = '0;
  logic [15:0]       frame_len = '0;
  logic [7:0]        loop_cnt = '0;
  logic [15:0]       lfsr_seed = '0;
  logic [W_ACC-1:0]  exp_acc = '0;
  logic              stop_on_fail = 1'b0;
  logic              bist_active;
  logic [TD_W-1:0]   bist_tdata;
  logic [7:0]        bist_tuser;
  logic              bist_tvalid;
  logic              bist_tready = 1'b1;
  logic              bist_tlast;
  logic [W_ACC-1:0]  obs_acc = '0;
  logic [7:0]        obs_tuser = '0;
  logic              obs_valid = 1'b0;
  logic              obs_last = 1'b0;
  logic [1:0]        bist_status;
  logic              poison_inject;
  logic [7:0]        fail_count;
  logic [7:0]        frames_done;
  logic              timeout_flag;

  ime_bist_seq #(.W_P(W_P), .W_LOG(W_LOG), .W_ACC(W_ACC), .DEPTH(DEPTH), .TO_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .bist_cmd(bist_cmd), .vect_sel(vect_sel), .tol(tol),
    .frame_len(frame_len), .loop_cnt(loop_cnt), .lfsr_seed(lfsr_seed), .exp_acc(exp_acc),
    .stop_on_fail(stop_on_fail), .bist_active(bist_active), .bist_tdata(bist_tdata),
    .bist_tuser(bist_tuser), .bist_tvalid(bist_tvalid), .bist_tready(bist_tready),
    .bist_tlast(bist_tlast), .obs_acc(obs_acc), .obs_tuser(obs_tuser), .obs_valid(obs_valid),
    .obs_last(obs_last), .bist_status(bist_status), .poison_inject(poison_inject),
    .fail_count(fail_count), .frames_done(frames_done), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TD_W-1:0] d;
    logic [7:0]      u;
    logic            l;
  } beat_t;

  beat_t exp_beats[$];
  int    checks = 0;
  int    errors = 0;
  int    beats_acc = 0;
  int    ready_mode = 0;

  int uni_t [4][3] = '{'{1024, 1024, 2048}, '{1024, 2048, 1536}, '{2048, 1024, 1280}, '{2048, 2048, 1024}};
  int dir_t [4][3] = '{'{4096, 128, 4096}, '{64, 128, 256}, '{32, 256, 128}, '{32, 256, 128}};
  int sym_t [4][3] = '{'{1536, 1664, 1408}, '{1664, 1536, 1344}, '{1600, 1600, 1312}, '{1600, 1600, 1312}};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic bound_expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [TD_W-1:0] model_beat(input int sel, input int k, input logic [15:0] st);
    logic [15:0] p, q, s;
    case (sel)
      0:       begin p = 16'(uni_t[k%4][0]); q = 16'(uni_t[k%4][1]); s = 16'(uni_t[k%4][2]); end
      1:       begin p = 16'(dir_t[k%4][0]); q = 16'(dir_t[k%4][1]); s = 16'(dir_t[k%4][2]); end
      2:       begin p = 16'(sym_t[k%4][0]); q = 16'(sym_t[k%4][1]); s = 16'(sym_t[k%4][2]); end
      default: begin p = st; q = ~st; s = {st[7:0], st[15:8]}; end
    endcase
    return {p, q, s};
  endfunction

  task automatic push_frame(input int sel, input int len, input logic [15:0] seed);
    logic [15:0] st;
    st = (seed == 16'd0) ? 16'h0001 : seed;
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.d = model_beat(sel, k, st);
      b.u = {3'(sel), 5'(k)};
      b.l = (k == len - 1);
      exp_beats.push_back(b);
      st = st[0] ? ((st >> 1) ^ 16'hB400) : (st >> 1);
    end
  endtask

  // Compare process: every beat presented is checked against the model queue head.
  logic [TD_W-1:0] prev_d;
  logic [7:0]      prev_u;
  logic            prev_l;
  logic            prev_stall = 1'b0;
  always @(negedge clk) begin
    check("poison_vs_status", poison_inject, bist_status == 2'b11);
    if (rst_n && bist_tvalid) begin
      if (prev_stall) begin
        check("stall_tdata", bist_tdata, prev_d);
        check("stall_tuser", bist_tuser, prev_u);
        check("stall_tlast", bist_tlast, prev_l);
      end
      if (exp_beats.size() == 0) begin
        check("unexpected_beat", bist_tvalid, 1'b0);
      end else begin
        check("beat_tdata", bist_tdata, exp_beats[0].d);
        check("beat_tuser", bist_tuser, exp_beats[0].u);
        check("beat_tlast", bist_tlast, exp_beats[0].l);
        if (bist_tready) begin
          void'(exp_beats.pop_front());
          beats_acc <= beats_acc + 1;
        end
      end
    end
    prev_stall <= rst_n && bist_tvalid && !bist_tready;
    prev_d     <= bist_tdata;
    prev_u     <= bist_tuser;
    prev_l     <= bist_tlast;
  end

  initial forever begin
    @(posedge clk);
    #1;
    bist_tready = (ready_mode == 0) ? 1'b1 : ~bist_tready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] sel, input int len, input int loops, input logic [7:0] t,
                       input logic [15:0] seed, input logic [31:0] e, input logic sof);
    vect_sel = sel; frame_len = 16'(len); loop_cnt = 8'(loops); tol = t;
    lfsr_seed = seed; exp_acc = e; stop_on_fail = sof;
    bist_cmd = 2'b01;
    tick();
    bist_cmd = 2'b00;
  endtask

  task automatic wait_wait(input string name);
    int n = 0;
    while (!(bist_active && !bist_tvalid) && n < 500) begin tick(); n++; end
    if (n >= 500) bound_expired(name);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (bist_status == 2'b01 && n < 500) begin tick(); n++; end
    if (n >= 500) bound_expired(name);
  endtask

  task automatic answer(input logic [31:0] acc, input logic [7:0] tu);
    obs_acc = acc; obs_tuser = tu; obs_valid = 1'b1; obs_last = 1'b1;
    tick();
    obs_valid = 1'b0; obs_last = 1'b0;
  endtask

  task automatic check_run(input string n, input logic [1:0] st, input int fr, input int fl,
                           input logic to, input logic po);
    check({n, "_status"}, bist_status, st);
    check({n, "_frames"}, frames_done, 8'(fr));
    check({n, "_fails"}, fail_count, 8'(fl));
    check({n, "_timeout"}, timeout_flag, to);
    check({n, "_poison"}, poison_inject, po);
    check({n, "_queue"}, exp_beats.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b0;
    // Reset state
    repeat (3) tick();
    check("rst_status", bist_status, 2'b00);
    check("rst_tvalid", bist_tvalid, 1'b0);
    check("rst_active", bist_active, 1'b0);
    check("rst_tdata", bist_tdata, 0);
    check("rst_tuser", bist_tuser, 0);
    check("rst_counts", {fail_count, frames_done, 6'd0, timeout_flag, poison_inject}, 0);
    rst_n = 1'b1;
    tick();

    // Uniform, 3 frames, each answered 4 off expected within tol 8
    push_frame(0, 4, 16'd0); push_frame(0, 4, 16'd0); push_frame(0, 4, 16'd0);
    start(3'd0, 4, 3, 8'd8, 16'd0, 32'd0, 1'b0);
    check("uni_first_tdata", bist_tdata, 48'h0400_0400_0800);
    repeat (3) begin wait_wait("uni_wait"); answer(32'd4100, 8'h03); end
    wait_done("uni_done");
    check_run("uni", 2'b10, 3, 0, 1'b0, 1'b0);

    // Dirac, frame_len 0 -> DEPTH beats, ready toggling
    ready_mode = 1;
    b0 = beats_acc;
    push_frame(1, DEPTH, 16'd0);
    start(3'd1, 0, 1, 8'd0, 16'd0, 32'd0, 1'b0);
    wait_wait("dirac_wait");
    check("dirac_beats", beats_acc - b0, DEPTH);
    answer(32'd8192, 8'h3F);
    wait_done("dirac_done");
    check_run("dirac", 2'b10, 1, 0, 1'b0, 1'b0);
    ready_mode = 0;

    // SymPerturb, no observation: both frames time out after TO_CYCLES wait cycles
    push_frame(2, 4, 16'd0); push_frame(2, 4, 16'd0);
    start(3'd2, 4, 2, 8'd0, 16'd0, 32'd0, 1'b0);
    wait_wait("sym_wait");
    n = 0;
    while (bist_active && !bist_tvalid && n < 100) begin tick(); n++; end
    check("sym_wait_cycles", n, TO_CYCLES);
    wait_done("sym_done");
    check_run("sym", 2'b11, 2, 2, 1'b1, 1'b1);

    // LFSR, seed 0, miss by 20 with stop_on_fail -> ends after first frame
    push_frame(3, 4, 16'd0);
    start(3'd3, 4, 4, 8'd8, 16'd0, 32'd500, 1'b1);
    check("lfsr_first_tdata", bist_tdata, 48'h0001_FFFE_0100);
    wait_wait("lfsr_wait");
    answer(32'd520, 8'h63);
    wait_done("lfsr_done");
    check_run("lfsr", 2'b11, 1, 1, 1'b0, 1'b1);

    // Rerun: each frame reloads the seed; last-cycle answer beats the timeout
    push_frame(3, 4, 16'd0); push_frame(3, 4, 16'd0);
    start(3'd3, 4, 2, 8'd8, 16'd0, 32'd500, 1'b0);
    check("rerun_f1_tdata", bist_tdata, 48'h0001_FFFE_0100);
    tick();
    check("rerun_beat2_tdata", bist_tdata, 48'hB400_4BFF_00B4);
    wait_wait("rerun_wait1");
    answer(32'd500, 8'h63);
    check("rerun_f2_tdata", bist_tdata, 48'h0001_FFFE_0100);
    wait_wait("rerun_wait2");
    repeat (TO_CYCLES - 1) tick();
    answer(32'd505, 8'h63);
    wait_done("rerun_done");
    check_run("rerun", 2'b10, 2, 0, 1'b0, 1'b0);

    // Abort in second frame at index 2 after a failed first frame
    push_frame(0, 8, 16'd0); push_frame(0, 8, 16'd0);
    start(3'd0, 8, 2, 8'd8, 16'd0, 32'd0, 1'b0);
    wait_wait("abort_wait");
    answer(32'd0, 8'h07);
    check("abort_pre_frames", frames_done, 8'd1);
    check("abort_pre_fails", fail_count, 8'd1);
    tick(); tick();
    check("abort_pre_tuser", bist_tuser, 8'h02);
    bist_cmd = 2'b10;
    tick();
    bist_cmd = 2'b00;
    exp_beats.delete();
    check("abort_tvalid", bist_tvalid, 1'b0);
    check("abort_active", bist_active, 1'b0);
    check("abort_status", bist_status, 2'b00);
    check("abort_counts", {fail_count, frames_done, 7'd0, timeout_flag}, 0);

    // Illegal selector -> immediate FAIL
    start(3'd5, 4, 1, 8'd0, 16'd0, 32'd0, 1'b0);
    check_run("illegal", 2'b11, 0, 1, 1'b0, 1'b1);
    check("illegal_tvalid", bist_tvalid, 1'b0);
    check("illegal_active", bist_active, 1'b0);

    // Reset mid-run abandons the frame
    push_frame(0, 8, 16'd0);
    start(3'd0, 8, 1, 8'd0, 16'd0, 32'd0, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    exp_beats.delete();
    check("midrst_tvalid", bist_tvalid, 1'b0);
    check("midrst_status", bist_status, 2'b00);
    check("midrst_fails", fail_count, 8'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("postrst_tvalid", bist_tvalid, 1'b0);
    check("postrst_active", bist_active, 1'b0);
    check("postrst_status", bist_status, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
